dmem_slow_resp: RTL and testbench
=================================

Name: dmem_slow_resp

Overview:
- Responder end of the cached-CPU memory interface: a word-line backing memory that answers one read or write request at a time after a fixed latency, handshaking with a one-cycle ready pulse.
- Sits below the data/instruction cache that the next processor revision places between the core and off-chip memory.
- Also serves as the bench memory model for that cache.

Parameters:
- ADDR_W, 28, line-address width on the bus.
- DATA_W, 128, line data width; must be a multiple of 32.
- DEPTH_LOG2, 8, log2 of the number of stored lines.
- LATENCY, 4, cycles from request to ready; must be >= 1.

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset, synchronous, active-low.
- mem_read  input  1  read request, level.
- mem_write  input  1  write request, level.
- mem_addr  input  ADDR_W  line address.
- mem_wdata  input  DATA_W  write line data.
- mem_rdata  output  DATA_W  read line data, registered.
- mem_ready  output  1  completion pulse, registered.

Behaviour:
- Storage: 2^DEPTH_LOG2 x DATA_W array, indexed by mem_addr[DEPTH_LOG2-1:0]; upper address bits are ignored, so addresses alias. Array contents are not cleared by reset.
- FSM states:
  - IDLE -> BUSY on (mem_read | mem_write) when LATENCY > 1.
  - IDLE -> DONE directly when LATENCY == 1.
  - BUSY -> DONE when the down-counter reaches 0.
  - DONE -> IDLE unconditionally.
- Capture: on the IDLE edge that accepts a request, latch op, index and wdata. The counter loads LATENCY-2 (unused when LATENCY == 1).
- Request priority: if both mem_read and mem_write are high, the request is a write and the read is ignored.
- Timing: a request first high in cycle 0 (in IDLE) gets mem_ready = 1 in cycle LATENCY, for exactly that one cycle.
- Read: mem_rdata = array[latched index], valid in the mem_ready cycle. It holds that value until the next read completes; writes do not change mem_rdata.
- Write: the array is updated at the edge ending the mem_ready cycle. A read accepted afterwards returns the new data.
- Input changes while in BUSY or DONE are ignored; only latched values are used.
- Requester protocol: drop the request in the cycle after it sees mem_ready. A request still high in that cycle (state is IDLE) is accepted as a new transaction. Back-to-back transactions therefore run at one per LATENCY+1 cycles.
- Reset values: state IDLE, counter 0, mem_ready 0, mem_rdata 0, latched op/index/wdata 0.
- Reset mid-transaction: the pending transaction is discarded. A pending write does not reach the array, and no ready pulse is issued.
- No combinational path from any input to any output.

Optional Feature:
- Macro: DMEM_SLOW_RESP_ERR_EN.
- Defined:
  - Adds output mem_err (1 bit, reset 0), registered, pulsing together with mem_ready.
  - mem_err = 1 if the latched request had both read and write high, or if mem_addr[ADDR_W-1:DEPTH_LOG2] was nonzero.
  - The transaction still completes exactly as described in Behaviour.
- Undefined: the mem_err port does not exist; aliasing and the write priority apply silently.

Test Plan:
- Reset values: hold rst_n = 0 for 2 cycles -> mem_ready = 0, mem_rdata = 0; no ready pulse for 10 cycles with requests low.
- Write then read (LATENCY = 4):
  - mem_write, addr 0x5, wdata 0x0123..CDEF in cycle 0 -> mem_ready only in cycle 4.
  - Drop the request; mem_read addr 0x5 in cycle 5 -> mem_ready in cycle 9, mem_rdata = 0x0123..CDEF.
- Back-to-back: hold mem_read high across ready at addrs 0x1 then 0x2 -> ready pulses in cycles 4 and 9, each returning the correct line.
- Latching: change mem_addr and mem_wdata every cycle while BUSY -> the array is written only at the address and data present in the accept cycle.
- Reset mid-op: mem_write addr 0x7 data 0xAA, rst_n = 0 in cycle 2 -> no mem_ready pulse; a subsequent read of 0x7 returns the old contents.
- Aliasing / error:
  - With DEPTH_LOG2 = 8, write addr 0x105, read addr 0x005 -> same data returned.
  - With DMEM_SLOW_RESP_ERR_EN, mem_err = 1 on the 0x105 write's ready cycle, and mem_err = 0 for the 0x005 read.
  - With mem_read and mem_write both high -> write performed, mem_err = 1.

Source files
------------

// File: rtl/dmem_slow_resp.sv
// Fixed-latency single-outstanding line memory answering cache fill/evict requests with a one-cycle ready pulse.
// Optional mem_err output (alias / read+write conflict) enabled by defining DMEM_SLOW_RESP_ERR_EN.
module dmem_slow_resp #(
    parameter int ADDR_W     = 28,
    parameter int DATA_W     = 128,
    parameter int DEPTH_LOG2 = 8,
    parameter int LATENCY    = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_ready
`ifdef DMEM_SLOW_RESP_ERR_EN
    ,
    output logic              mem_err
`endif
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int CNT_W = $clog2(LATENCY + 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t                  state, state_nxt;
    logic [CNT_W-1:0]        cnt, cnt_nxt;
    logic                    op_wr;
    logic [DEPTH_LOG2-1:0]   idx;
    logic [DATA_W-1:0]       wdata_q;
    logic [DATA_W-1:0]       mem [DEPTH];

    logic                    req;
    logic                    accept;
    logic                    fin_wr;
    logic [DEPTH_LOG2-1:0]   fin_idx;

    assign req    = mem_read | mem_write;
    assign accept = (state == IDLE) && req;
    // With LATENCY == 1 completion happens on the accept edge, so the live inputs are used.
    assign fin_wr  = accept ? mem_write : op_wr;
    assign fin_idx = accept ? mem_addr[DEPTH_LOG2-1:0] : idx;

`ifdef DMEM_SLOW_RESP_ERR_EN
    logic err_q;
    logic err_in;
    logic fin_err;
    assign err_in  = (mem_read & mem_write) | (|mem_addr[ADDR_W-1:DEPTH_LOG2]);
    assign fin_err = accept ? err_in : err_q;
`else
    logic unused_addr_hi;
    assign unused_addr_hi = |mem_addr[ADDR_W-1:DEPTH_LOG2];
`endif

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (req) begin
                    if (LATENCY == 1) begin
                        state_nxt = DONE;
                    end else begin
                        state_nxt = BUSY;
                        cnt_nxt   = CNT_W'(LATENCY - 2);
                    end
                end
            end
            BUSY: begin
                if (cnt == '0) state_nxt = DONE;
                else           cnt_nxt   = cnt - CNT_W'(1);
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            mem_ready <= 1'b0;
            mem_rdata <= '0;
            op_wr     <= 1'b0;
            idx       <= '0;
            wdata_q   <= '0;
`ifdef DMEM_SLOW_RESP_ERR_EN
            err_q     <= 1'b0;
            mem_err   <= 1'b0;
`endif
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            mem_ready <= (state_nxt == DONE);
            if (accept) begin
                op_wr   <= mem_write;
                idx     <= mem_addr[DEPTH_LOG2-1:0];
                wdata_q <= mem_wdata;
`ifdef DMEM_SLOW_RESP_ERR_EN
                err_q   <= err_in;
`endif
            end
            if (state_nxt == DONE && !fin_wr) begin
                mem_rdata <= mem[fin_idx];
            end
`ifdef DMEM_SLOW_RESP_ERR_EN
            mem_err <= (state_nxt == DONE) && fin_err;
`endif
        end
    end

    // Storage is not reset; a reset during the ready cycle still suppresses the write.
    always_ff @(posedge clk) begin
        if (rst_n && state == DONE && op_wr) begin
            mem[idx] <= wdata_q;
        end
    end

endmodule

// File: tb/tb_dmem_slow_resp.sv
// Randomized scoreboard bench for dmem_slow_resp against an abstract line-memory model.
module tb_dmem_slow_resp;

    localparam int ADDR_W = 28;
    localparam int DATA_W = 128;
    localparam int DL     = 8;
    localparam int LAT    = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;
`ifdef DMEM_SLOW_RESP_ERR_EN
    logic              mem_err;
`endif

    dmem_slow_resp #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH_LOG2(DL), .LATENCY(LAT)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .mem_read (mem_read),
        .mem_write(mem_write),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .mem_ready(mem_ready)
`ifdef DMEM_SLOW_RESP_ERR_EN
        ,
        .mem_err  (mem_err)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DATA_W-1:0] rdata;
        bit                chk;
        bit                err;
    } exp_t;

    exp_t              sbq[$];
    logic [DATA_W-1:0] model[int];
    logic [DATA_W-1:0] last_rd;
    bit                last_known;
    int                checks = 0;
    int                errors = 0;

    task automatic check(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every ready pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && mem_ready === 1'b1) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ready: got ready=1 expected no pulse");
            end else begin
                exp_t e;
                e = sbq.pop_front();
                if (e.chk) check("rdata", mem_rdata, e.rdata);
`ifdef DMEM_SLOW_RESP_ERR_EN
                check("mem_err", {127'b0, mem_err}, {127'b0, e.err});
`endif
            end
        end
    end

    // Issues one request at posedge+1 and returns at posedge+1 of the cycle after ready, request still held.
    task automatic txn(input bit rd, input bit wr, input logic [ADDR_W-1:0] addr,
                       input logic [DATA_W-1:0] wd, input bit scramble);
        exp_t e;
        int   i;
        int   cyc;
        i     = int'(addr[DL-1:0]);
        e.err = (rd && wr) || (addr[ADDR_W-1:DL] != 0);
        if (wr) begin
            model[i] = wd;
            e.rdata  = last_rd;
            e.chk    = last_known;
        end else if (model.exists(i)) begin
            e.rdata    = model[i];
            e.chk      = 1'b1;
            last_rd    = model[i];
            last_known = 1'b1;
        end else begin
            e.rdata    = '0;
            e.chk      = 1'b0;
            last_known = 1'b0;
        end
        sbq.push_back(e);
        mem_read  = rd;
        mem_write = wr;
        mem_addr  = addr;
        mem_wdata = wd;
        cyc = 0;
        forever begin
            @(negedge clk);
            if (mem_ready) break;
            if (scramble && cyc > 0) begin
                mem_addr  = ADDR_W'($urandom_range(0, 15));
                mem_wdata = {$urandom, $urandom, $urandom, $urandom};
            end
            cyc++;
            if (cyc > 50) break;
        end
        check("latency", DATA_W'(cyc), DATA_W'(LAT));
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        mem_read  = 1'b0;
        mem_write = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        logic [DATA_W-1:0] d0;
        d0         = 128'h0123456789ABCDEF_0123456789ABCDEF;
        last_rd    = '0;
        last_known = 1'b1;
        rst_n      = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_ready", {127'b0, mem_ready}, '0);
        check("reset_rdata", mem_rdata, '0);
        rst_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("idle_ready", {127'b0, mem_ready}, '0);
        end
        @(posedge clk);
        #1;

        // Write then read, back-to-back reads, aliasing.
        txn(1'b0, 1'b1, 28'h5, d0, 1'b0);
        txn(1'b1, 1'b0, 28'h5, '0, 1'b0);
        idle(1);
        txn(1'b0, 1'b1, 28'h1, {4{32'h11111111}}, 1'b0);
        txn(1'b0, 1'b1, 28'h2, {4{32'h22222222}}, 1'b0);
        idle(1);
        txn(1'b1, 1'b0, 28'h1, '0, 1'b0);
        txn(1'b1, 1'b0, 28'h2, '0, 1'b0);
        idle(2);
        txn(1'b0, 1'b1, 28'h105, {4{32'hCAFEF00D}}, 1'b0);
        idle(1);
        txn(1'b1, 1'b0, 28'h005, '0, 1'b0);
        idle(1);
        txn(1'b1, 1'b1, 28'h9, {4{32'h99990000}}, 1'b0);
        idle(1);
        txn(1'b1, 1'b0, 28'h9, '0, 1'b0);
        idle(1);

        // Inputs scrambled while busy must not affect the latched write.
        txn(1'b0, 1'b1, 28'hC, {4{32'h0C0C0C0C}}, 1'b1);
        idle(1);
        txn(1'b1, 1'b0, 28'hC, '0, 1'b0);
        idle(1);

        // Reset in the middle of a write discards it.
        txn(1'b0, 1'b1, 28'h7, {4{32'h55555555}}, 1'b0);
        idle(1);
        mem_write = 1'b1;
        mem_addr  = 28'h7;
        mem_wdata = 128'hAA;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n     = 1'b0;
        mem_write = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("midreset_ready", {127'b0, mem_ready}, '0);
        check("midreset_rdata", mem_rdata, '0);
        rst_n      = 1'b1;
        last_rd    = '0;
        last_known = 1'b1;
        idle(6);
        txn(1'b1, 1'b0, 28'h7, '0, 1'b0);
        idle(1);

        // Random traffic over a small index pool, with occasional aliasing upper bits.
        for (int n = 0; n < 80; n++) begin
            int op;
            int gap;
            logic [ADDR_W-1:0] a;
            op = $urandom_range(0, 5);
            a  = ADDR_W'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) a[ADDR_W-1:DL] = 20'($urandom_range(1, 255));
            txn(op <= 2 || op == 5, op >= 3, a, {$urandom, $urandom, $urandom, $urandom},
                bit'($urandom_range(0, 1)));
            gap = $urandom_range(0, 2);
            if (gap != 0) idle(gap);
        end
        idle(8);
        check("scoreboard_empty", DATA_W'(sbq.size()), '0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
